// File: rtl/seq_div.sv
// seq_div - 16-bit by 8-bit unsigned sequential restoring divider.
//
// Ports:
//   clk   in   1  single clock, all state on its rising edge
//   rst   in   1  asynchronous active-high reset
//   start in   1  request to begin a division (accepted in IDLE or DONE)
//   a     in  16  unsigned dividend, captured on the accept edge
//   b     in   8  unsigned divisor, captured on the accept edge
//   q     out 16  registered quotient of the most recent completion
//   r     out  8  registered remainder of the most recent completion
//   busy  out  1  high while a division is in progress (RUN)
//   done  out  1  one-cycle pulse marking q/r/dbz valid (DONE)
//   dbz   out  1  divide-by-zero flag of the most recent result
//
// A normal division takes 16 RUN cycles, one quotient bit per cycle. A zero
// divisor spends a single RUN cycle and then reports q=FFFF, r=0, dbz=1.
module seq_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [7:0]  b,
  output logic [15:0] q,
  output logic [7:0]  r,
  output logic        busy,
  output logic        done,
  output logic        dbz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;   // dividend shifting out, quotient shifting in
  logic [7:0]  div_q,   div_d;
  logic [8:0]  rem_q,   rem_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        zero_q,  zero_d;    // accepted divisor was zero
  logic [15:0] quot_q,  quot_d;
  logic [7:0]  remo_q,  remo_d;
  logic        dbz_q,   dbz_d;

  logic [8:0]  rem_shift;
  logic [8:0]  rem_sub;
  logic        fits;
  logic [8:0]  rem_step;
  logic [15:0] shreg_step;

  // The remainder is always below the divisor between steps, so its top bit
  // is zero and dropping it in the shift loses nothing.
  assign rem_shift  = 9'({rem_q, shreg_q[15]});
  assign fits       = (rem_shift >= {1'b0, div_q});
  assign rem_sub    = rem_shift - {1'b0, div_q};
  assign rem_step   = fits ? rem_sub : rem_shift;
  assign shreg_step = {shreg_q[14:0], fits};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shreg_d = a;
          div_d   = b;
          rem_d   = 9'd0;
          cnt_d   = 4'd0;
          zero_d  = (b == 8'd0);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (zero_q) begin
          zero_d  = 1'b0;
          quot_d  = 16'hFFFF;
          remo_d  = 8'h00;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          rem_d   = rem_step;
          shreg_d = shreg_step;
          cnt_d   = cnt_q + 4'd1;        // wraps 15 -> 0 on the last step
          if (cnt_q == 4'd15) begin
            quot_d  = shreg_step;
            remo_d  = rem_step[7:0];
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= 16'd0;
      div_q   <= 8'd0;
      rem_q   <= 9'd0;
      cnt_q   <= 4'd0;
      zero_q  <= 1'b0;
      quot_q  <= 16'd0;
      remo_q  <= 8'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Status decodes straight from the state register so reset clears them
  // at once.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign q    = quot_q;
  assign r    = remo_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [7:0]  b;
  logic [15:0] q;
  logic [7:0]  r;
  logic        busy;
  logic        done;
  logic        dbz;

  seq_div dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dbz  (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("q", 32'(q), 32'(e.q));
        chk("r", 32'(r), 32'(e.r));
        chk("dbz", 32'(dbz), 32'(e.dbz));
        $display("result q=%0d r=%0d dbz=%0d at cycle %0d", q, r, dbz, cyc);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a one-cycle start; returns just after the accept edge with the
  // expected result queued. Inputs are scrambled after accept.
  task automatic issue(input logic [15:0] av, input logic [7:0] bv, output int lat);
    exp_t e;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 8'($urandom);
    if (bv == 8'd0) begin
      lat   = 1;
      e.q   = 16'hFFFF;
      e.r   = 8'h00;
      e.dbz = 1'b1;
    end else begin
      lat   = 16;
      e.q   = 16'(int'(av) / int'(bv));
      e.r   = 8'(int'(av) % int'(bv));
      e.dbz = 1'b0;
    end
    e.cyc = cyc + lat;
    sb.push_back(e);
    $display("issue a=%0d b=%0d expect q=%0d r=%0d dbz=%0d", av, bv, e.q, e.r, e.dbz);
  endtask

  int lat;
  int busy_cnt;
  logic [15:0] q_hold;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 16'd0;
    b = 8'd0;
    #12;
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_r", 32'(r), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic case with busy-length and output-hold checks.
    issue(16'd1000, 8'd7, lat);
    busy_cnt = busy ? 1 : 0;
    q_hold = q;
    for (int i = 1; i < 16; i++) begin
      wait_cycles(1);
      if (busy) busy_cnt++;
      chk("q_hold_in_run", 32'(q), 32'(q_hold));
    end
    wait_cycles(1);
    chk("busy_after_run", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'd16);
    chk("basic_q", 32'(q), 32'h008E);
    wait_cycles(1);
    chk("done_single", 32'(done), 32'd0);

    // Boundary cases.
    issue(16'hFFFF, 8'hFF, lat); wait_cycles(lat + 1);
    issue(16'hFFFF, 8'h01, lat); wait_cycles(lat + 1);
    issue(16'd5, 8'd9, lat);     wait_cycles(lat + 1);

    // Divide by zero.
    issue(16'h1234, 8'd0, lat);
    chk("dbz_busy_e0", 32'(busy), 32'd1);
    wait_cycles(1);
    chk("dbz_busy_e1", 32'(busy), 32'd0);
    wait_cycles(1);

    // Start ignored in RUN, then back-to-back start in DONE.
    issue(16'd100, 8'd3, lat);
    wait_cycles(4);
    a = 16'd50; b = 8'd5; start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(11);
    chk("ignored_done_state", 32'(done), 32'd1);
    issue(16'd50, 8'd5, lat);
    wait_cycles(lat + 1);

    // Mid-operation reset.
    issue(16'd1000, 8'd7, lat);
    wait_cycles(7);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_r", 32'(r), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dbz", 32'(dbz), 32'd0);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(12);
    chk("midrst_no_done", 32'(done), 32'd0);
    issue(16'd1000, 8'd7, lat);
    wait_cycles(lat + 1);

    // Randomized operations, sometimes back-to-back.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] av;
      logic [7:0]  bv;
      av = 16'($urandom);
      bv = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bv = 8'd0;
      if ($urandom_range(0, 7) == 0) bv = 8'd1;
      issue(av, bv, lat);
      wait_cycles(lat);
      if ($urandom_range(0, 1) == 1) wait_cycles(1);
    end

    // Drain the scoreboard with a bounded wait.
    begin
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 40) begin
        wait_cycles(1);
        guard++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
    end
    wait_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
